seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment driver for N-digit common-anode displays: the next-generation display back-end for the calendar/clock.
Takes packed BCD digits and per-digit control masks, and scans the digits at a programmable refresh rate.
Adds tear-free frame-synchronous loading, leading-zero suppression, per-digit blink, decimal points and PWM brightness.
Sits between the timekeeping/date logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 100_000, clk cycles per digit slot; must be a multiple of 16 and >= 16
BLINK_DIV, 50_000_000, clk cycles per blink half-period

Ports:
clk_100MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
digits_bcd  input  4*NUM_DIGITS  packed BCD; nibble i = digit i, i=0 least significant (rightmost)
digit_en  input  NUM_DIGITS  1 = digit may light; 0 = forced blank
blink_mask  input  NUM_DIGITS  1 = digit blinks
dp_mask  input  NUM_DIGITS  1 = decimal point lit on that digit
lzs_en  input  1  leading-zero suppression enable
brightness  input  4  0 = dimmest (1/16 duty), 15 = full duty
load  input  1  one-cycle strobe: capture all data/mask inputs
seg  output  7  active-low segments; seg[6]=a … seg[0]=g
dp  output  1  active-low decimal point
an  output  NUM_DIGITS  active-low anodes; an[i] drives digit i
frame_tick  output  1  one-cycle pulse on the last cycle of each full scan

Behaviour:
- Reset (async assert, sync release):
  - an all 1s, seg 7'h7F, dp 1, frame_tick 0.
  - Scan index = NUM_DIGITS-1; slot timer 0; blink timer 0; blink phase 0.
  - Pending and display registers cleared: digits 0, all masks 0, lzs 0, brightness 0.
- Loading:
  - On load=1, all inputs are captured into pending registers; multiple loads in a frame, last wins.
  - Pending is copied to display registers at the frame boundary only, so a frame never shows mixed data.
  - Frame boundary = slot timer == REFRESH_DIV-1 and index == 0.
  - If load coincides with the boundary, the incoming inputs go straight to the display registers as well as to pending.
- Scanning:
  - Slot timer counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the index decrements, wrapping 0 -> NUM_DIGITS-1.
  - Scan order is MSD first.
  - frame_tick = 1 exactly on the boundary cycle.
- Output timing: all outputs are registered and reflect the current index/timer with one-cycle latency.
- PWM:
  - phase = slot_timer / (REFRESH_DIV/16).
  - The anode for the current digit is asserted only while phase <= display brightness; otherwise an is all 1s and seg/dp are all 1s.
- Decode:
  - BCD 0..9 maps to the standard segment patterns.
  - Codes 10..15 blank all segments; dp still follows dp_mask.
- Blanking: a digit shows all segments off and dp off when any of these holds:
  - digit_en=0
  - blink_mask=1 and blink phase=1
  - suppressed by leading-zero suppression
- Leading-zero suppression: with lzs_en=1, contiguous zero digits from the MSD downward are suppressed. Digit 0 is never suppressed. A digit whose dp_mask=1 stops suppression at and below it.
- Blink: the blink timer counts 0..BLINK_DIV-1 free-running and toggles the phase at wrap. It is independent of the scan.
- reset_n assertion mid-frame immediately forces the reset values; scanning restarts at index NUM_DIGITS-1.

Decomposition:
- Package seg7_pkg holds:
  - Active-low segment constants SEG_0..SEG_9 and SEG_BLANK.
  - Brightness width constant (4).
  - Function bcd_to_seg.
- One sub-module, seg7_decoder: combinational nibble -> 7-bit active-low pattern, using bcd_to_seg.
- Scan, PWM, blink, shadow-load and LZS logic stay in seg7_scan_driver.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=16, BLINK_DIV=64.
1. Reset then load digits=16'h1234, all en, brightness=15 -> an cycles 0111, 1011, 1101, 1110 every 16 clks. seg = 1, 2, 3, 4 patterns (7'b1001111, 0010010, 0000110, 1001100). frame_tick every 64 clks.
2. Mid-frame load 16'h5678 while displaying 1234 -> rest of current frame still shows 1234; next frame shows 5678. Load on the boundary cycle -> 5678 appears in the immediately following frame.
3. lzs_en=1, digits 16'h0005 -> digits 3..1 blank, digit 0 shows 5. Digits 16'h0000 -> only digit 0 shows 0. dp_mask=4'b0100 with 16'h0005 -> digit 3 blank, digit 2 shows 0 with dp=0.
4. brightness=3 -> each slot's anode is low for exactly 4 of 16 cycles (phases 0..3). brightness=0 -> 1 cycle per slot.
5. blink_mask=4'b0001 -> digit 0 shows for 64 clks, blank for 64 clks, alternately; other digits unaffected. Digit nibble 4'hB -> seg 7'h7F.
6. Assert reset_n=0 during slot 2 -> same-cycle an all 1s, seg 7'h7F. After release, the first lit digit is digit 3 with digits 0 until a load.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display back-end.
//   - SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, bit 6 = a ... bit 0 = g
//   - BRIGHT_W                : width of the brightness / PWM phase field
//   - PWM_STEPS               : number of PWM phases per digit slot
//   - bcd_to_seg()            : BCD nibble -> active-low pattern, codes 10..15 blank
package seg7_pkg;

  localparam int unsigned BRIGHT_W  = 4;
  localparam int unsigned PWM_STEPS = 16;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i : BCD nibble (10..15 decode to all segments off)
//   seg_o : active-low segments, seg_o[6] = a ... seg_o[0] = g
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment scan driver.
// Captures packed BCD digits and per-digit masks on load into a pending frame, promotes it
// to the displayed frame only at the frame boundary (tear-free), and scans MSD first with
// PWM brightness, per-digit blink, decimal points and leading-zero suppression.
//   clk_100MHz  : system clock
//   reset_n     : asynchronous active-low reset
//   digits_bcd  : packed BCD, nibble i = digit i (digit 0 rightmost)
//   digit_en    : per-digit enable (0 = forced blank)
//   blink_mask  : per-digit blink enable
//   dp_mask     : per-digit decimal point
//   lzs_en      : leading-zero suppression enable
//   brightness  : 0 = 1/16 duty ... 15 = full duty
//   load        : one-cycle strobe capturing all of the above
//   seg, dp, an : active-low segment, decimal point and anode drives (registered)
//   frame_tick  : one-cycle pulse marking the last cycle of each full scan
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_DIV   = 50_000_000
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzs_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  // The slot timer is kept as (phase, sub) so the PWM phase needs no divider:
  // slot_timer = phase * SubDiv + sub.
  localparam int unsigned SubDiv = REFRESH_DIV / PWM_STEPS;
  localparam int unsigned SubW   = (SubDiv > 1) ? $clog2(SubDiv) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SubW-1:0]     SubLast   = SubW'(SubDiv - 1);
  localparam logic [IdxW-1:0]     IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0]   BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [BRIGHT_W-1:0] PhaseLast = BRIGHT_W'(PWM_STEPS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lzs;
    logic [BRIGHT_W-1:0]     bright;
  } frame_t;

  // Scan / blink state
  logic [SubW-1:0]     sub_q, sub_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;

  // Shadow frames
  frame_t in_frame;
  frame_t pend_q, pend_d;
  frame_t disp_q, disp_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_last;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] suppress;
  logic                  lzs_run;
  logic [3:0]            cur_bcd;
  logic [6:0]            cur_seg;
  logic                  lit;
  logic                  blank;

  always_comb begin
    in_frame.digits = digits_bcd;
    in_frame.en     = digit_en;
    in_frame.blink  = blink_mask;
    in_frame.dp     = dp_mask;
    in_frame.lzs    = lzs_en;
    in_frame.bright = brightness;
  end

  // ---------------------------------------------------------------------------
  // Slot timer and scan index
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_last = (sub_q == SubLast) && (phase_q == PhaseLast);
    boundary  = slot_last && (idx_q == '0);
  end

  always_comb begin
    sub_d   = sub_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (sub_q == SubLast) begin
      sub_d = '0;
      if (phase_q == PhaseLast) begin
        phase_d = '0;
        // MSD first: count the index down, wrapping 0 -> NUM_DIGITS-1
        idx_d = (idx_q == '0) ? IdxLast : idx_q - 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end else begin
      sub_d = sub_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running blink timer, independent of the scan
  // ---------------------------------------------------------------------------
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow loading: pending takes every load, display changes only on the boundary.
  // A load on the boundary itself bypasses pending so it is not a frame late.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    disp_d = disp_q;
    if (load) begin
      pend_d = in_frame;
    end
    if (boundary) begin
      disp_d = load ? in_frame : pend_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression: walk down from the MSD while digits are zero and carry
  // no decimal point. Digit 0 is never suppressed.
  // ---------------------------------------------------------------------------
  always_comb begin
    lzs_run  = disp_q.lzs;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_q.dp[i] || (disp_q.digits[4*i +: 4] != 4'd0)) begin
        lzs_run = 1'b0;
      end
      suppress[i] = lzs_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit decode and output formation
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_bcd = disp_q.digits[{idx_q, 2'b00} +: 4];
  end

  seg7_decoder u_decoder (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  always_comb begin
    lit   = (phase_q <= disp_q.bright);
    blank = !disp_q.en[idx_q] || (disp_q.blink[idx_q] && blink_ph_q) || suppress[idx_q];

    an_d         = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    frame_tick_d = boundary;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      if (!blank) begin
        seg_d = cur_seg;
        dp_d  = ~disp_q.dp[idx_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sub_q        <= '0;
      phase_q      <= '0;
      idx_q        <= IdxLast;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=16, BLINK_DIV=64).
// A cycle-level reference model derives every output from the elapsed cycle count since
// reset and the frame contents; a monitor compares each registered output word.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int R  = 16;
  localparam int B  = 64;
  localparam int FR = N * R;

  localparam logic [6:0] SEGS [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                       7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  // {frame_tick, dp, seg, an}
  localparam logic [12:0] RST_OUT = {1'b0, 1'b1, 7'h7F, 4'hF};

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  blk;
    logic [3:0]  dpm;
    logic        lzs;
    logic [3:0]  br;
  } frm_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] digits_bcd = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic        lzs_en = 1'b0;
  logic [3:0]  brightness = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int          n_cmp = 0;
  int          n_err = 0;
  string       scen = "reset";

  int          m_c = 0;
  frm_t        m_pend = '0;
  frm_t        m_disp = '0;
  logic [12:0] exp_q [$];

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .digits_bcd (digits_bcd),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .lzs_en     (lzs_en),
    .brightness (brightness),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got {ft,dp,seg,an}=%h expected %h", name, m_c, act, exp);
    end
  endtask

  function automatic frm_t cur_in();
    frm_t f;
    f.dig = digits_bcd;
    f.en  = digit_en;
    f.blk = blink_mask;
    f.dpm = dp_mask;
    f.lzs = lzs_en;
    f.br  = brightness;
    return f;
  endfunction

  function automatic int nib(input frm_t f, input int i);
    return int'((f.dig >> (4 * i)) & 16'hF);
  endfunction

  // Expected output word for state cycle c (c counted from reset release).
  function automatic logic [12:0] model_out(input int c, input frm_t f);
    int         idx;
    int         t;
    int         d;
    bit         bp;
    bit         ft;
    bit         lit;
    bit         sup;
    bit         blank;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    idx = N - 1 - (c / R) % N;
    t   = c % R;
    bp  = ((c / B) % 2) == 1;
    ft  = (c % FR) == FR - 1;
    d   = nib(f, idx);
    lit = (t / (R / 16)) <= int'(f.br);
    sup = f.lzs && (idx != 0);
    for (int j = idx; j < N; j++) begin
      if (nib(f, j) != 0 || f.dpm[j]) sup = 1'b0;
    end
    blank = !f.en[idx] || (f.blk[idx] && bp) || sup;
    an_e  = lit ? ~(4'b0001 << idx) : 4'hF;
    seg_e = (lit && !blank) ? ((d < 10) ? SEGS[d] : 7'h7F) : 7'h7F;
    dp_e  = (lit && !blank) ? !f.dpm[idx] : 1'b1;
    return {ft, dp_e, seg_e, an_e};
  endfunction

  // Reference model: runs on the same edge as the DUT and queues the expected output.
  initial begin
    bit bnd;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_c    = 0;
        m_pend = '0;
        m_disp = '0;
        exp_q.delete();
      end else begin
        exp_q.push_back(model_out(m_c, m_disp));
        bnd = (m_c % FR) == FR - 1;
        if (bnd) m_disp = load ? cur_in() : m_pend;
        if (load) m_pend = cur_in();
        m_c++;
      end
    end
  end

  // Monitor: compare on the falling edge, away from the active edge.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n || exp_q.size() == 0) e = RST_OUT;
      else e = exp_q.pop_front();
      check(scen, {frame_tick, dp, seg, an}, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] en, input logic [3:0] blk,
                         input logic [3:0] dpm, input logic lz, input logic [3:0] br);
    digits_bcd = dg;
    digit_en   = en;
    blink_mask = blk;
    dp_mask    = dpm;
    lzs_en     = lz;
    brightness = br;
    load       = 1'b1;
    tick(1);
    load       = 1'b0;
    // Inputs without load must not reach the display
    digits_bcd = 16'($urandom);
    digit_en   = 4'($urandom);
    blink_mask = 4'($urandom);
    dp_mask    = 4'($urandom);
    lzs_en     = 1'($urandom);
    brightness = 4'($urandom);
  endtask

  task automatic wait_mod(input int target);
    int k;
    k = 0;
    while ((m_c % FR) != target && k < 2 * FR) begin
      tick(1);
      k++;
    end
    if ((m_c % FR) != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_mod: cycle slot %0d never reached target %0d", m_c % FR, target);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(FR);

    scen = "basic_1234";
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 4'd15);
    tick(3 * FR);

    scen = "midframe_load";
    wait_mod(30);
    do_load(16'h5678, 4'hF, 4'h0, 4'h0, 1'b0, 4'd15);
    tick(2 * FR);

    scen = "boundary_load";
    wait_mod(40);
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 4'd15);
    wait_mod(FR - 1);
    do_load(16'h5678, 4'hF, 4'h0, 4'h0, 1'b0, 4'd15);
    tick(2 * FR);

    scen = "lzs";
    do_load(16'h0005, 4'hF, 4'h0, 4'h0, 1'b1, 4'd15);
    tick(2 * FR);
    do_load(16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 4'd15);
    tick(2 * FR);
    do_load(16'h0005, 4'hF, 4'h0, 4'b0100, 1'b1, 4'd15);
    tick(2 * FR);

    scen = "brightness";
    do_load(16'h9876, 4'hF, 4'h0, 4'hA, 1'b0, 4'd3);
    tick(2 * FR);
    do_load(16'h9876, 4'hF, 4'h0, 4'h5, 1'b0, 4'd0);
    tick(2 * FR);

    scen = "blink";
    do_load(16'h1234, 4'hF, 4'b0001, 4'h0, 1'b0, 4'd15);
    tick(5 * FR);
    do_load(16'h12B4, 4'b1011, 4'h0, 4'b0010, 1'b0, 4'd15);
    tick(2 * FR);

    scen = "async_reset";
    wait_mod(20);
    reset_n = 1'b0;
    #1 check("async_reset_now", {frame_tick, dp, seg, an}, RST_OUT);
    tick(2);
    reset_n = 1'b1;
    tick(2 * FR);

    scen = "random";
    repeat (30) begin
      tick($urandom_range(1, 90));
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
              4'($urandom));
    end
    tick(3 * FR);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
